// File: rtl/pattern_shift_sequencer.sv
// pattern_shift_sequencer: programmable shift/rotate pattern generator with
// wrap strobe, zero-lock recovery and optional period measurement.
// Optional feature macro: SEQ_PERIOD_MEAS_EN (step_count / last_period logic).
module pattern_shift_sequencer #(
   parameter int              WIDTH    = 8,
   parameter logic [WIDTH-1:0] SEED     = 8'h05,
   parameter logic [WIDTH-1:0] WRAP_A   = 8'hA0,
   parameter logic [WIDTH-1:0] RELOAD_A = 8'h41,
   parameter logic [WIDTH-1:0] WRAP_B   = 8'h82,
   parameter int              CNT_W    = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] cct_output,
   output logic             wrap_pulse,
   output logic             stuck_err,
   output logic [CNT_W-1:0] step_count,
   output logic [CNT_W-1:0] last_period
);

   logic [WIDTH-1:0] nxt_raw;
   logic [WIDTH-1:0] nxt;
   logic             nxt_zero;
   logic             load_zero;
   logic             adv;
   logic             adv_seed;

   // Next-pattern selection for an advance; a zero result is replaced by SEED.
   always_comb begin
      nxt_raw = cct_output;
      case (mode)
         2'b00: begin
            if (cct_output == WRAP_B)      nxt_raw = SEED;
            else if (cct_output == WRAP_A) nxt_raw = RELOAD_A;
            else                           nxt_raw = cct_output << 1;
         end
         2'b01:   nxt_raw = {cct_output[WIDTH-2:0], cct_output[WIDTH-1]};
         2'b10:   nxt_raw = {cct_output[0], cct_output[WIDTH-1:1]};
         default: nxt_raw = cct_output;
      endcase
      nxt_zero  = (nxt_raw == '0);
      nxt       = nxt_zero ? SEED : nxt_raw;
      load_zero = (load_value == '0);
      adv       = en && (mode != 2'b11);
      adv_seed  = adv && (nxt == SEED);
   end

   // Pattern register, wrap strobe and sticky zero-lock flag.
   always_ff @(posedge clk) begin
      if (clear) begin
         cct_output <= SEED;
         wrap_pulse <= 1'b0;
         stuck_err  <= 1'b0;
      end else if (load) begin
         cct_output <= load_zero ? SEED : load_value;
         wrap_pulse <= 1'b0;
         if (load_zero) stuck_err <= 1'b1;
      end else if (adv) begin
         cct_output <= nxt;
         wrap_pulse <= adv_seed;
         if (nxt_zero) stuck_err <= 1'b1;
      end else begin
         wrap_pulse <= 1'b0;
      end
   end

`ifdef SEQ_PERIOD_MEAS_EN
   logic [CNT_W-1:0] step_inc;

   // Saturating increment shared by the step counter and period capture.
   always_comb begin
      step_inc = (step_count == '1) ? step_count : step_count + 1'b1;
   end

   // Step counter restarts on clear/load/wrap; a wrap captures the period.
   always_ff @(posedge clk) begin
      if (clear) begin
         step_count  <= '0;
         last_period <= '0;
      end else if (load) begin
         step_count  <= '0;
      end else if (adv) begin
         if (adv_seed) begin
            step_count  <= '0;
            last_period <= step_inc;
         end else begin
            step_count  <= step_inc;
         end
      end
   end
`else
   assign step_count  = '0;
   assign last_period = '0;
`endif

endmodule

// File: tb/tb_pattern_shift_sequencer.sv
// Bench for pattern_shift_sequencer: directed vector table from the test plan,
// a saturation sequence, then randomized traffic against a behavioural model.
module tb_pattern_shift_sequencer;

   logic       clk = 1'b0;
   logic       clear, en, load;
   logic [7:0] load_value;
   logic [1:0] mode;
   logic [7:0] cct_output, step_count, last_period;
   logic       wrap_pulse, stuck_err;

   int n_cmp = 0;
   int n_bad = 0;

   pattern_shift_sequencer dut (
      .clk(clk), .clear(clear), .en(en), .load(load), .load_value(load_value),
      .mode(mode), .cct_output(cct_output), .wrap_pulse(wrap_pulse),
      .stuck_err(stuck_err), .step_count(step_count), .last_period(last_period)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       c, e, l;
      logic [7:0] lv;
      logic [1:0] m;
      logic [7:0] out;
      logic       wrap, stuck;
      int         step, last;
   } vec_t;

   vec_t vecs[$];

   function automatic int meas(int v);
`ifdef SEQ_PERIOD_MEAS_EN
      return v;
`else
      return 0;
`endif
   endfunction

   task automatic addv(input logic c, e, l, input logic [7:0] lv, input logic [1:0] m,
                       input logic [7:0] out, input logic wrap, stuck, input int step, last);
      vec_t v;
      v.c = c; v.e = e; v.l = l; v.lv = lv; v.m = m;
      v.out = out; v.wrap = wrap; v.stuck = stuck; v.step = step; v.last = last;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic c, e, l, input logic [7:0] lv, input logic [1:0] m);
      clear = c; en = e; load = l; load_value = lv; mode = m;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [7:0] out, input logic wrap, stuck,
                          input int step, input int last);
      chk({tag, ".out"},   int'(cct_output),  int'(out));
      chk({tag, ".wrap"},  int'(wrap_pulse),  int'(wrap));
      chk({tag, ".stuck"}, int'(stuck_err),   int'(stuck));
      chk({tag, ".step"},  int'(step_count),  meas(step));
      chk({tag, ".last"},  int'(last_period), meas(last));
   endtask

   // Behavioural model: plain arithmetic on integers.
   int m_out, m_step, m_last;
   bit m_wrap, m_stuck;

   function automatic int model_next(int cur, int md);
      int r;
      case (md)
         0: r = (cur == 'h82) ? 'h05 : (cur == 'hA0) ? 'h41 : (cur * 2) % 256;
         1: r = ((cur * 2) % 256) + (cur / 128);
         2: r = (cur / 2) + (cur % 2) * 128;
         default: r = cur;
      endcase
      return r;
   endfunction

   task automatic model_step(input bit c, e, l, input int lv, input int md);
      int n;
      if (c) begin
         m_out = 5; m_wrap = 0; m_stuck = 0; m_step = 0; m_last = 0;
      end else if (l) begin
         m_wrap = 0; m_step = 0;
         if (lv == 0) begin m_out = 5; m_stuck = 1; end
         else m_out = lv;
      end else if (e && md != 3) begin
         n = model_next(m_out, md);
         if (n == 0) begin n = 5; m_stuck = 1; end
         m_out = n;
         if (n == 5) begin
            m_wrap = 1;
            m_last = (m_step + 1 > 255) ? 255 : m_step + 1;
            m_step = 0;
         end else begin
            m_wrap = 0;
            m_step = (m_step + 1 > 255) ? 255 : m_step + 1;
         end
      end else begin
         m_wrap = 0;
      end
   endtask

   initial begin
      clear = 0; en = 0; load = 0; load_value = 0; mode = 0;

      // c e l lv m | out wrap stuck step last
      addv(1,0,0,8'h00,0, 8'h05,0,0,0,0);        // reset state
      addv(0,1,0,8'h00,0, 8'h0A,0,0,1,0);        // legacy sequence
      addv(0,1,0,8'h00,0, 8'h14,0,0,2,0);
      addv(0,1,0,8'h00,0, 8'h28,0,0,3,0);
      addv(0,1,0,8'h00,0, 8'h50,0,0,4,0);
      addv(0,1,0,8'h00,0, 8'hA0,0,0,5,0);
      addv(0,1,0,8'h00,0, 8'h41,0,0,6,0);
      addv(0,1,0,8'h00,0, 8'h82,0,0,7,0);
      addv(0,1,0,8'h00,0, 8'h05,1,0,0,8);
      addv(0,1,0,8'h00,2, 8'h82,0,0,1,8);        // rotate right
      addv(0,1,0,8'h00,2, 8'h41,0,0,2,8);
      addv(0,1,0,8'h00,2, 8'hA0,0,0,3,8);
      addv(0,1,0,8'h00,2, 8'h50,0,0,4,8);
      addv(0,1,0,8'h00,2, 8'h28,0,0,5,8);
      addv(0,1,0,8'h00,2, 8'h14,0,0,6,8);
      addv(0,1,0,8'h00,2, 8'h0A,0,0,7,8);
      addv(0,1,0,8'h00,2, 8'h05,1,0,0,8);
      addv(0,1,0,8'h00,3, 8'h05,0,0,0,8);        // mode 11 holds
      addv(0,1,0,8'h00,3, 8'h05,0,0,0,8);
      addv(0,1,0,8'h00,3, 8'h05,0,0,0,8);
      addv(0,1,0,8'h00,1, 8'h0A,0,0,1,8);        // one step, then hold nonzero count
      addv(0,1,0,8'h00,3, 8'h0A,0,0,1,8);
      addv(0,0,0,8'h00,0, 8'h0A,0,0,1,8);
      addv(0,0,1,8'hC0,0, 8'hC0,0,0,0,8);        // load C0
      addv(0,1,0,8'h00,0, 8'h80,0,0,1,8);
      addv(0,1,0,8'h00,0, 8'h05,1,1,0,2);        // zero-lock recovery
      addv(0,0,0,8'h00,0, 8'h05,0,1,0,2);
      addv(0,0,1,8'h11,0, 8'h11,0,1,0,2);        // load keeps stuck_err
      addv(0,0,1,8'h00,0, 8'h05,0,1,0,2);        // zero load
      addv(1,0,0,8'h00,0, 8'h05,0,0,0,0);        // clear drops stuck_err
      addv(0,1,0,8'h00,0, 8'h0A,0,0,1,0);
      addv(0,1,0,8'h00,0, 8'h14,0,0,2,0);
      addv(0,1,0,8'h00,0, 8'h28,0,0,3,0);
      addv(1,1,1,8'h33,0, 8'h05,0,0,0,0);        // clear beats load
      addv(0,1,0,8'h00,0, 8'h0A,0,0,1,0);
      addv(0,1,0,8'h00,0, 8'h14,0,0,2,0);
      addv(0,1,0,8'h00,0, 8'h28,0,0,3,0);
      addv(0,1,0,8'h00,0, 8'h50,0,0,4,0);
      addv(0,1,0,8'h00,1, 8'hA0,0,0,5,0);        // switch to rotate left at 50
      addv(0,1,0,8'h00,1, 8'h41,0,0,6,0);
      addv(0,1,0,8'h00,1, 8'h82,0,0,7,0);
      addv(0,1,0,8'h00,1, 8'h05,1,0,0,8);
      addv(0,1,1,8'h11,0, 8'h11,0,0,0,8);        // load beats en

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].c, vecs[i].e, vecs[i].l, vecs[i].lv, vecs[i].m);
         chk_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].wrap, vecs[i].stuck,
                 vecs[i].step, vecs[i].last);
      end

      // Step counter saturation: FF rotates onto itself and never wraps.
      drive(0, 0, 1, 8'hFF, 1);
      for (int i = 0; i < 260; i++) drive(0, 1, 0, 8'h00, 1);
      chk_all("sat", 8'hFF, 0, 0, 255, 8);

      // Randomized traffic against the model.
      drive(1, 0, 0, 8'h00, 0);
      model_step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         bit c, e, l;
         int lv, md;
         c  = ($urandom_range(99) < 2);
         l  = ($urandom_range(99) < 8);
         e  = ($urandom_range(99) < 85);
         lv = ($urandom_range(4) == 0) ? 0 : $urandom_range(255);
         md = $urandom_range(3);
         drive(c, e, l, lv[7:0], md[1:0]);
         model_step(c, e, l, lv, md);
         chk_all($sformatf("rnd%0d", i), m_out[7:0], m_wrap, m_stuck, m_step, m_last);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
